// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer: sequencer states,
// hazard priority encoding, stage-control bundle and the resolver helpers.
package pipe_ctrl_pkg;

  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    WAIT  = 2'd1,
    ERROR = 2'd2
  } seq_state_e;

  // Winning hazard for the current cycle; enum order mirrors increasing priority.
  typedef enum logic [2:0] {
    HZ_NONE      = 3'd0,
    HZ_JUMP      = 3'd1,
    HZ_LOAD_USE  = 3'd2,
    HZ_BRANCH    = 3'd3,
    HZ_MEM_STALL = 3'd4,
    HZ_ERROR     = 3'd5
  } hazard_e;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic ifid_flush;
    logic idex_flush;
    logic memwb_bubble;
  } stage_ctrl_t;

  function automatic hazard_e hazard_select(input logic in_error,
                                            input logic mem_stall,
                                            input logic branch_taken,
                                            input logic load_use,
                                            input logic jump);
    hazard_e hz;
    if (in_error)          hz = HZ_ERROR;
    else if (mem_stall)    hz = HZ_MEM_STALL;
    else if (branch_taken) hz = HZ_BRANCH;
    else if (load_use)     hz = HZ_LOAD_USE;
    else if (jump)         hz = HZ_JUMP;
    else                   hz = HZ_NONE;
    return hz;
  endfunction

  function automatic stage_ctrl_t hazard_ctrl(input hazard_e hz);
    stage_ctrl_t c;
    c.pc_en        = 1'b1;
    c.ifid_en      = 1'b1;
    c.idex_en      = 1'b1;
    c.exmem_en     = 1'b1;
    c.ifid_flush   = 1'b0;
    c.idex_flush   = 1'b0;
    c.memwb_bubble = 1'b0;
    case (hz)
      HZ_ERROR, HZ_MEM_STALL: begin
        c.pc_en        = 1'b0;
        c.ifid_en      = 1'b0;
        c.idex_en      = 1'b0;
        c.exmem_en     = 1'b0;
        c.memwb_bubble = 1'b1;
      end
      HZ_BRANCH: begin
        c.ifid_flush = 1'b1;
        c.idex_flush = 1'b1;
      end
      HZ_LOAD_USE: begin
        // Hold PC and IFID; IDEX takes a bubble so the consumer waits one cycle.
        c.pc_en      = 1'b0;
        c.ifid_en    = 1'b0;
        c.idex_flush = 1'b1;
      end
      HZ_JUMP: begin
        c.ifid_flush = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/pipe_hazard_sequencer_load_use_detect.sv
// Combinational load-use comparator: a load in EX whose destination is a
// source of the instruction in ID. Register 0 never creates a dependency.
module load_use_detect #(
  parameter int AW = 5
) (
  input  logic [AW-1:0] id_rs,
  input  logic [AW-1:0] id_rt,
  input  logic          id_uses_rt,
  input  logic          ex_mem_read,
  input  logic [AW-1:0] ex_rd,
  output logic          load_use
);

  // Compare the EX load destination against the ID sources.
  always_comb begin
    load_use = ex_mem_read & (ex_rd != '0) &
               ((ex_rd == id_rs) | (id_uses_rt & (ex_rd == id_rt)));
  end

endmodule

// File: rtl/pipe_hazard_sequencer.sv
// Stall/flush sequencer for the five-stage pipeline. Resolves load-use,
// taken-branch, jump and data-memory-wait hazards into stage-register
// enables/flushes, and traps a data memory that never answers.
// Optional build macro PIPE_PERF_CNT_EN adds stall_cycles/flush_events.
module pipe_hazard_sequencer #(
  parameter int REG_ADDR_W  = pipe_ctrl_pkg::REG_ADDR_W,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rt,
  input  logic                  id_jump,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_branch_taken,
  input  logic                  mem_access,
  input  logic                  dmem_ready,
  output logic                  pc_en,
  output logic                  ifid_en,
  output logic                  idex_en,
  output logic                  exmem_en,
  output logic                  ifid_flush,
  output logic                  idex_flush,
  output logic                  memwb_bubble,
  output logic                  mem_error
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [31:0]           stall_cycles,
  output logic [31:0]           flush_events
`endif
);

  import pipe_ctrl_pkg::*;

  // State | meaning
  // RUN   | normal issue; hazards resolved combinationally each cycle
  // WAIT  | data memory has not answered; wait_cnt counts stall cycles
  // ERROR | memory timeout trapped; pipeline frozen until reset

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(MEM_TIMEOUT);

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             mem_stall;
  logic             load_use;
  hazard_e          hz;
  stage_ctrl_t      ctrl;

  assign mem_stall = mem_access & ~dmem_ready;

  load_use_detect #(.AW(REG_ADDR_W)) u_load_use (
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rt  (id_uses_rt),
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .load_use    (load_use)
  );

  // State and wait-counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Next state and saturating wait counter; first stall cycle sees wait_cnt 0.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = '0;
    case (state_q)
      RUN: begin
        if (mem_stall) state_d = WAIT;
      end
      WAIT: begin
        if (!mem_stall)                      state_d = RUN;
        else if (wait_cnt_q == TIMEOUT_CNT)  state_d = ERROR;
      end
      ERROR:   state_d = ERROR;
      default: state_d = RUN;
    endcase
    if (mem_stall && (state_q != ERROR)) begin
      wait_cnt_d = (wait_cnt_q == '1) ? wait_cnt_q : wait_cnt_q + 1'b1;
    end
  end

  // Hazard resolution; reset forces a frozen pipeline with a WB bubble.
  always_comb begin
    hz   = hazard_select(state_q == ERROR, mem_stall, ex_branch_taken, load_use, id_jump);
    ctrl = hazard_ctrl(hz);
    if (reset) begin
      ctrl              = '0;
      ctrl.memwb_bubble = 1'b1;
    end
    pc_en        = ctrl.pc_en;
    ifid_en      = ctrl.ifid_en;
    idex_en      = ctrl.idex_en;
    exmem_en     = ctrl.exmem_en;
    ifid_flush   = ctrl.ifid_flush;
    idex_flush   = ctrl.idex_flush;
    memwb_bubble = ctrl.memwb_bubble;
    mem_error    = (state_q == ERROR);
  end

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] flush_events_q, flush_events_d;

  // Free-running wrap-around event counters.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_events_d = flush_events_q;
    if (!pc_en)     stall_cycles_d = stall_cycles_q + 32'd1;
    if (ifid_flush) flush_events_d = flush_events_q + 32'd1;
  end

  // Counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles_q <= '0;
      flush_events_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_events_q <= flush_events_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_events = flush_events_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_sequencer.sv
`timescale 1ns/1ps
module tb_pipe_hazard_sequencer;

  localparam int AW  = 5;
  localparam int TMO = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] id_rs, id_rt, ex_rd;
  logic          id_uses_rt, id_jump, ex_mem_read, ex_branch_taken, mem_access, dmem_ready;
  logic          pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, memwb_bubble, mem_error;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0]   stall_cycles, flush_events;
`endif

  always #5 clk = ~clk;

  pipe_hazard_sequencer #(.REG_ADDR_W(AW), .MEM_TIMEOUT(TMO)) dut (
    .clk             (clk),
    .reset           (reset),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_uses_rt      (id_uses_rt),
    .id_jump         (id_jump),
    .ex_mem_read     (ex_mem_read),
    .ex_rd           (ex_rd),
    .ex_branch_taken (ex_branch_taken),
    .mem_access      (mem_access),
    .dmem_ready      (dmem_ready),
    .pc_en           (pc_en),
    .ifid_en         (ifid_en),
    .idex_en         (idex_en),
    .exmem_en        (exmem_en),
    .ifid_flush      (ifid_flush),
    .idex_flush      (idex_flush),
    .memwb_bubble    (memwb_bubble),
    .mem_error       (mem_error)
`ifdef PIPE_PERF_CNT_EN
    ,
    .stall_cycles    (stall_cycles),
    .flush_events    (flush_events)
`endif
  );

  typedef struct packed {
    logic          rst;
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
    logic          urt;
    logic          jmp;
    logic          mrd;
    logic [AW-1:0] rd;
    logic          br;
    logic          macc;
    logic          rdy;
  } stim_t;

  typedef struct {
    logic [7:0]  ctl;   // {pc,ifid,idex,exmem,ifid_fl,idex_fl,bubble,err}
    logic [31:0] stalls;
    logic [31:0] flushes;
    int          cyc;
  } exp_t;

  exp_t        sb_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc_no = 0;
  bit          stim_done = 0;

  // reference model: consecutive memory-stall run length and sticky trap
  int          m_run = 0;
  bit          m_err = 0;
  logic [31:0] m_stalls = '0;
  logic [31:0] m_flushes = '0;

  function automatic stim_t nop();
    stim_t s;
    s = '0;
    s.rdy = 1'b1;
    return s;
  endfunction

  task automatic step(input stim_t s);
    exp_t       e;
    logic [7:0] v;
    logic       ms, lu;
    @(posedge clk);
    #1;
    reset = s.rst; id_rs = s.rs; id_rt = s.rt; id_uses_rt = s.urt; id_jump = s.jmp;
    ex_mem_read = s.mrd; ex_rd = s.rd; ex_branch_taken = s.br;
    mem_access = s.macc; dmem_ready = s.rdy;
    ms = s.macc && !s.rdy;
    lu = s.mrd && (s.rd != 0) && ((s.rd == s.rs) || (s.urt && (s.rd == s.rt)));
    if (s.rst) begin
      m_err = 0; m_run = 0; m_stalls = '0; m_flushes = '0;
      v = 8'b0000_0010;
    end else if (m_err)  v = 8'b0000_0011;
    else if (ms)         v = 8'b0000_0010;
    else if (s.br)       v = 8'b1111_1100;
    else if (lu)         v = 8'b0011_0100;
    else if (s.jmp)      v = 8'b1111_1000;
    else                 v = 8'b1111_0000;
    e.ctl = v; e.stalls = m_stalls; e.flushes = m_flushes; e.cyc = cyc_no;
    sb_q.push_back(e);
    cyc_no++;
    if (!s.rst) begin
      if (!v[7]) m_stalls = m_stalls + 1;
      if (v[3])  m_flushes = m_flushes + 1;
      if (!m_err) begin
        if (ms) begin
          m_run++;
          if (m_run == TMO + 1) m_err = 1;
        end else m_run = 0;
      end
    end
  endtask

  // Monitor: pops one expectation per cycle and compares away from the edge.
  initial begin
    exp_t       e;
    logic [7:0] got;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        got = {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, memwb_bubble, mem_error};
        n_cmp++;
        if (got !== e.ctl) begin
          n_bad++;
          $display("FAIL ctl cyc=%0d got=%b exp=%b", e.cyc, got, e.ctl);
        end
`ifdef PIPE_PERF_CNT_EN
        n_cmp++;
        if (stall_cycles !== e.stalls) begin
          n_bad++;
          $display("FAIL stall_cycles cyc=%0d got=%0d exp=%0d", e.cyc, stall_cycles, e.stalls);
        end
        n_cmp++;
        if (flush_events !== e.flushes) begin
          n_bad++;
          $display("FAIL flush_events cyc=%0d got=%0d exp=%0d", e.cyc, flush_events, e.flushes);
        end
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t s;
    reset = 1'b1; id_rs = '0; id_rt = '0; id_uses_rt = 0; id_jump = 0;
    ex_mem_read = 0; ex_rd = '0; ex_branch_taken = 0; mem_access = 0; dmem_ready = 1;

    s = nop(); s.rst = 1; step(s); step(s);
    s = nop(); step(s);

    // load-use on rs: one stall then normal
    s = nop(); s.mrd = 1; s.rd = 8; s.rs = 8; s.rt = 3; step(s);
    s = nop(); step(s);
    // r0 never hazards
    s = nop(); s.mrd = 1; s.rd = 0; s.rs = 0; step(s);
    // rt match but rt unused, then used
    s = nop(); s.mrd = 1; s.rd = 9; s.rt = 9; s.rs = 1; step(s);
    s.urt = 1; step(s);
    // branch beats load-use
    s = nop(); s.mrd = 1; s.rd = 8; s.rs = 8; s.br = 1; step(s);
    // jump alone
    s = nop(); s.jmp = 1; step(s);
    // memory wait of 3 cycles
    s = nop(); s.macc = 1; s.rdy = 0; s.br = 1; s.jmp = 1; step(s); step(s); step(s);
    s.rdy = 1; s.br = 0; s.jmp = 0; step(s);
    s = nop(); step(s);
    // memory timeout, error held, then reset out of it
    s = nop(); s.macc = 1; s.rdy = 0;
    for (int i = 0; i < 8; i++) step(s);
    s = nop(); s.jmp = 1; step(s);
    s = nop(); s.rst = 1; step(s);
    s = nop(); step(s);
    // reset mid-wait restarts cleanly
    s = nop(); s.macc = 1; s.rdy = 0; step(s); step(s);
    s.rst = 1; step(s);
    s.rst = 0; step(s); step(s);
    s = nop(); step(s);
    // counter scenario: 2 load-use stalls and 1 branch after reset
    s = nop(); s.rst = 1; step(s);
    s = nop(); s.mrd = 1; s.rd = 5; s.rs = 5; step(s);
    s = nop(); step(s);
    s = nop(); s.mrd = 1; s.rd = 6; s.rt = 6; s.urt = 1; step(s);
    s = nop(); s.br = 1; step(s);
    s = nop(); step(s);

    // randomized traffic
    for (int i = 0; i < 500; i++) begin
      s = nop();
      s.rst  = ($urandom_range(0, 79) == 0);
      s.rs   = AW'($urandom_range(0, 3));
      s.rt   = AW'($urandom_range(0, 3));
      s.rd   = AW'($urandom_range(0, 3));
      s.urt  = $urandom_range(0, 1);
      s.mrd  = $urandom_range(0, 1);
      s.br   = ($urandom_range(0, 7) == 0);
      s.jmp  = ($urandom_range(0, 7) == 0);
      s.macc = ($urandom_range(0, 2) == 0);
      s.rdy  = ($urandom_range(0, 9) < 4);
      step(s);
    end
    s = nop(); step(s);
    stim_done = 1;
  end

  initial begin
    wait (stim_done);
    for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    if (sb_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain pending=%0d exp=0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_sequencer.md
# pipe_hazard_sequencer

Central stall/flush sequencer for the five-stage MIPS32 pipeline (IF, ID, EX, MEM, WB). It drives the enables and flushes of the PC register and the IFID, IDEX, EXMEM and MEMWB buffers from four sources: load-use hazards, taken branches resolved in EX, jumps resolved in ID, and a variable-latency data-memory handshake. It sits beside the forwarding unit. A timeout state machine traps a data memory that never answers.

## Interface
Parameters:
- REG_ADDR_W, 5, register-address width
- MEM_TIMEOUT, 16, maximum consecutive memory-wait cycles before error (legal range 1..255)

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-high reset
- id_rs  in  REG_ADDR_W  rs field of the instruction in ID
- id_rt  in  REG_ADDR_W  rt field of the instruction in ID
- id_uses_rt  in  1  ID instruction reads rt
- id_jump  in  1  ID holds j/jal/jr
- ex_mem_read  in  1  EX holds a load
- ex_rd  in  REG_ADDR_W  destination register of the EX instruction
- ex_branch_taken  in  1  branch resolved taken in EX
- mem_access  in  1  MEM holds a load or store
- dmem_ready  in  1  data memory completes the access this cycle
- pc_en, ifid_en, idex_en, exmem_en  out  1 each  stage-register load enables
- ifid_flush, idex_flush  out  1 each  load a NOP or bubble instead of data
- memwb_bubble  out  1  MEMWB captures a bubble (reg_write=0)
- mem_error  out  1  sticky memory-timeout flag

## Operation
- States: RUN, WAIT, ERROR.
- mem_stall = mem_access & ~dmem_ready.
- load_use = ex_mem_read & (ex_rd != 0) & ((ex_rd == id_rs) | (id_uses_rt & ex_rd == id_rt)).
- Priority, highest first: ERROR > mem_stall > ex_branch_taken > load_use > id_jump > normal.
- ERROR: all enables 0, flushes 0, memwb_bubble 1, mem_error 1.
- mem_stall:
  - pc_en, ifid_en, idex_en, exmem_en = 0; memwb_bubble = 1.
  - Branch and load-use are not acted on. They re-evaluate once the stall clears, because the pipeline contents are frozen.
- ex_branch_taken: all enables 1; ifid_flush = 1 and idex_flush = 1, which kills the two wrong-path instructions.
- load_use:
  - pc_en = 0 and ifid_en = 0.
  - idex_en = 1 with idex_flush = 1, which inserts one bubble.
  - exmem_en = 1.
- id_jump: all enables 1; ifid_flush = 1.
- Normal: all enables 1, flushes 0, memwb_bubble 0.
- Transitions:
  - RUN→WAIT on mem_stall.
  - WAIT→RUN on dmem_ready, or when mem_access drops.
  - WAIT→ERROR when wait_cnt reaches MEM_TIMEOUT with mem_stall still high.
  - ERROR is left only by reset.
- wait_cnt:
  - Width $clog2(MEM_TIMEOUT+1), saturating.
  - Increments on each mem_stall cycle.
  - Clears on any cycle without mem_stall.

## Timing
- All hazard outputs are combinational from the inputs and the registered state, with zero-cycle latency. The stage registers sample them on the same clk edge.
- A load-use stall lasts exactly 1 cycle, because the load moves to MEM and load_use deasserts.
- Memory timeout: the cycle on which mem_stall rises is wait_cnt=0. ERROR is entered after MEM_TIMEOUT+1 consecutive stall cycles. mem_error rises on that edge.
- dmem_ready in the same cycle as mem_access means no stall and wait_cnt stays 0.
- Reset:
  - Asynchronous; forces state RUN, wait_cnt 0, mem_error 0.
  - While reset is high: all enables 0, flushes 0, memwb_bubble 1.
  - Deassertion mid-wait restarts cleanly in RUN.

## Configuration
- PIPE_PERF_CNT_EN defined:
  - Adds outputs stall_cycles[31:0] and flush_events[31:0], both reset to 0 and wrapping at 2^32.
  - stall_cycles increments on every cycle with pc_en=0 outside reset, ERROR included.
  - flush_events increments on every cycle with ifid_flush=1.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

## Structure
- Package pipe_ctrl_pkg:
  - State enum (RUN, WAIT, ERROR).
  - Hazard-priority encoding.
  - Shared REG_ADDR_W constant.
- Sub-module load_use_detect: combinational load_use comparator, reusable by the branch-in-ID variant.

## Test plan
- ex_mem_read=1, ex_rd=8, id_rs=8 → one cycle of pc_en=0, ifid_en=0, idex_flush=1; normal the next cycle.
- ex_mem_read=1, ex_rd=0, id_rs=0 → no stall.
- ex_mem_read=1, ex_rd=9, id_rt=9, id_uses_rt=0 → no stall.
- ex_branch_taken=1 together with load_use=1 → ifid_flush=1, idex_flush=1, pc_en=1.
- id_jump=1 alone → ifid_flush=1 only.
- mem_access=1, dmem_ready low for 3 cycles then high → enables 0 and memwb_bubble 1 for 3 cycles, then normal; mem_error stays 0.
- mem_access=1, dmem_ready held low with MEM_TIMEOUT=4 → ERROR after 5 stall cycles, mem_error=1 held, pc_en=0. Asserting reset clears mem_error and returns to RUN.
- With PIPE_PERF_CNT_EN: 2 load-use stalls plus 1 branch → stall_cycles=2, flush_events=1.
